// File: rtl/gat_pkg.sv
// Shared helpers for the GAT host-to-core BRAM loaders.
// Address split and geometry derived from the core entry width.
package gat_pkg;

  localparam int TOP_W = 32;

  function automatic int calc_beats(input int dw);
    return (dw + TOP_W - 1) / TOP_W;
  endfunction

  function automatic int calc_slog2(input int dw);
    int s;
    s = $clog2(calc_beats(dw));
    return (s < 1) ? 1 : s;
  endfunction

  function automatic int calc_haddr_w(input int depth, input int dw);
    return $clog2(depth) + calc_slog2(dw) + 2;
  endfunction

  function automatic int beat_idx(input logic [31:0] a, input int slog2);
    return int'((a >> 2) & ((32'd1 << slog2) - 32'd1));
  endfunction

  function automatic int ent_idx(input logic [31:0] a, input int slog2);
    return int'(a >> (slog2 + 2));
  endfunction

endpackage

// File: rtl/gat_beat_packer.sv
// Stages 32-bit host beats and emits one wide core write per entry.
// Writing the last beat commits; earlier missing beats flag a partial entry.
module gat_beat_packer
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH = 72,
  parameter int DEPTH      = 4096,
  localparam int BEATS     = calc_beats(DATA_WIDTH),
  localparam int SLOG2     = calc_slog2(DATA_WIDTH),
  localparam int ENT_W     = $clog2(DEPTH),
  localparam int HADDR_W   = calc_haddr_w(DEPTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [31:0]           din,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [HADDR_W-1:0]    addr,
  output logic                  wr_en,
  output logic [ENT_W-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  commit,
  output logic                  partial,
  output logic                  drop
);

  localparam int SW  = BEATS * 32;
  localparam int REM = DATA_WIDTH % 32;
  localparam logic [31:0] LAST_MASK =
    (REM == 0) ? '1 : 32'((33'd1 << REM) - 33'd1);
  localparam logic [BEATS-1:0] LAST_BIT =
    BEATS'(1) << (BEATS - 1);

  int               ent;
  int               beat;
  logic             in_rng;
  logic             hit;
  logic             last;
  logic [31:0]      bdata;
  logic [SW-1:0]    stage_q;
  logic [SW-1:0]    merged;
  logic [BEATS-1:0] mask_q;

  always_comb begin
    ent    = ent_idx(32'(addr), SLOG2);
    beat   = beat_idx(32'(addr), SLOG2);
    in_rng = (ent < DEPTH) && (beat < BEATS);
    hit    = ena && wea && in_rng;
    drop   = ena && wea && !in_rng;
    last   = (beat == BEATS - 1);
    commit = hit && last;
    bdata  = last ? (din & LAST_MASK) : din;
    merged = stage_q;
    for (int b = 0; b < BEATS; b++)
      if (b == beat) merged[b*32 +: 32] = bdata;
    partial = commit && ((mask_q | LAST_BIT) != '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      stage_q <= '0;
      mask_q  <= '0;
    end else if (clr) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      stage_q <= '0;
      mask_q  <= '0;
    end else begin
      wr_en <= commit;
      if (hit) stage_q <= merged;
      if (commit) begin
        wr_addr <= ENT_W'(ent);
        wr_data <= merged[DATA_WIDTH-1:0];
        mask_q  <= '0;
      end else if (hit) begin
        mask_q <= mask_q | (BEATS'(1) << beat);
      end
    end
  end

endmodule

// File: rtl/gat_bram_wide_loader.sv
// Host AXI-BRAM bridge to one wide GAT core BRAM: packs writes,
// counts committed entries, and slices wide read data back to 32 bits.
module gat_bram_wide_loader
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH  = 32,
  parameter int DATA_WIDTH = 72,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 2,
  localparam int BEATS     = calc_beats(DATA_WIDTH),
  localparam int SLOG2     = calc_slog2(DATA_WIDTH),
  localparam int ENT_W     = $clog2(DEPTH),
  localparam int HADDR_W   = calc_haddr_w(DEPTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TOP_WIDTH-1:0]  host_din,
  input  logic                  host_ena,
  input  logic                  host_wea,
  input  logic [HADDR_W-1:0]    host_addra,
  input  logic                  host_enb,
  input  logic [HADDR_W-1:0]    host_addrb,
  output logic [TOP_WIDTH-1:0]  host_dout,
  input  logic [ENT_W:0]        cfg_expected,
  input  logic                  ext_done,
  input  logic                  clr,
  output logic                  core_wr_en,
  output logic [ENT_W-1:0]      core_wr_addr,
  output logic [DATA_WIDTH-1:0] core_wr_data,
  output logic [ENT_W-1:0]      core_rd_addr,
  input  logic [DATA_WIDTH-1:0] core_rd_data,
  output logic                  load_done,
  output logic [ENT_W:0]        entry_cnt,
  output logic                  err_addr,
  output logic                  err_partial
);

  localparam int SW    = BEATS * 32;
  localparam int CNT_W = ENT_W + 1;

  logic commit;
  logic partial;
  logic drop;

  gat_beat_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .din     (host_din),
    .ena     (host_ena),
    .wea     (host_wea),
    .addr    (host_addra),
    .wr_en   (core_wr_en),
    .wr_addr (core_wr_addr),
    .wr_data (core_wr_data),
    .commit  (commit),
    .partial (partial),
    .drop    (drop)
  );

  int               rent;
  int               rbeat;
  logic [SW-1:0]    padded;
  logic [31:0]      rd_slice;
  logic [RD_LAT:0]  rd_vld;
  logic [RD_LAT:0]  rd_ok;
  logic [SLOG2-1:0] rd_beat [RD_LAT+1];

  always_comb begin
    rent     = ent_idx(32'(host_addrb), SLOG2);
    rbeat    = beat_idx(32'(host_addrb), SLOG2);
    padded   = SW'(core_rd_data);
    rd_slice = '0;
    for (int b = 0; b < BEATS; b++)
      if (b == int'(rd_beat[RD_LAT])) rd_slice = padded[b*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_cnt    <= '0;
      load_done    <= 1'b0;
      err_addr     <= 1'b0;
      err_partial  <= 1'b0;
      core_rd_addr <= '0;
      host_dout    <= '0;
      rd_vld       <= '0;
      rd_ok        <= '0;
      for (int i = 0; i <= RD_LAT; i++) rd_beat[i] <= '0;
    end else if (clr) begin
      entry_cnt    <= '0;
      load_done    <= 1'b0;
      err_addr     <= 1'b0;
      err_partial  <= 1'b0;
      core_rd_addr <= '0;
      host_dout    <= '0;
      rd_vld       <= '0;
      rd_ok        <= '0;
      for (int i = 0; i <= RD_LAT; i++) rd_beat[i] <= '0;
    end else begin
      if (commit && entry_cnt != CNT_W'(DEPTH))
        entry_cnt <= entry_cnt + CNT_W'(1);
      if ((cfg_expected != '0 && entry_cnt == cfg_expected) || ext_done)
        load_done <= 1'b1;
      if (drop)    err_addr    <= 1'b1;
      if (partial) err_partial <= 1'b1;
      // beat index travels alongside the core read latency
      if (host_enb) core_rd_addr <= ENT_W'(rent);
      rd_vld     <= {rd_vld[RD_LAT-1:0], host_enb};
      rd_ok      <= {rd_ok[RD_LAT-1:0],
                     (rent < DEPTH) && (rbeat < BEATS)};
      rd_beat[0] <= SLOG2'(rbeat);
      for (int i = 1; i <= RD_LAT; i++) rd_beat[i] <= rd_beat[i-1];
      if (rd_vld[RD_LAT])
        host_dout <= rd_ok[RD_LAT] ? rd_slice : '0;
    end
  end

endmodule
